// File: rtl/bcd_conv_pkg.sv
// Shared types and sizing helpers for the parametrised binary-to-BCD converter.
package bcd_conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int bcd_w(input int digits);
        return 4 * digits;
    endfunction

    // Bits needed to hold the value BIN_W in the bit counter.
    function automatic int cnt_w(input int bin_w);
        int w;
        w = 0;
        while ((1 << w) < (bin_w + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_conv_param_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3, kept within its own nibble.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_conv_param.sv
// Multi-cycle binary-to-BCD converter with busy, sticky overflow and optional signed input.
// Build macro: BCD_CONV_SIGNED_EN adds two's-complement input and a sign_out port.
//
// state | meaning
// IDLE  | waiting for en; captures operand on accept
// SETUP | loads the bit counter with BIN_W
// ADD   | +3 on every BCD digit >= 5
// SHIFT | shifts {bcd, bin} left, collects overflow, counts down
// DONE  | publishes result and ovf, pulses rdy
module bcd_conv_param
    import bcd_conv_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [BIN_W-1:0]      bin_d_in,
    output logic [4*DIGITS-1:0]   bcd_d_out,
    output logic                  rdy,
    output logic                  busy,
    output logic                  ovf
`ifdef BCD_CONV_SIGNED_EN
    ,
    output logic                  sign_out
`endif
);

    localparam int BW = bcd_w(DIGITS);
    localparam int CW = cnt_w(BIN_W);
    localparam logic [BIN_W-1:0] BIN_ONE = BIN_W'(1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(BIN_W);

    state_t            state_q;
    state_t            state_d;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_adj;
    logic [BIN_W-1:0]  bin_q;
    logic [BIN_W-1:0]  mag;
    logic [CW-1:0]     cnt_q;
    logic              sticky_q;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (bcd_q[4*g +: 4]),
                .digit_out (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

`ifdef BCD_CONV_SIGNED_EN
    logic sign_in;
    logic sign_q;

    // Most-negative input wraps to itself, which reads correctly as the unsigned magnitude.
    always_comb begin
        sign_in = bin_d_in[BIN_W-1];
        mag     = bin_d_in;
        if (sign_in) begin
            mag = ~bin_d_in + BIN_ONE;
        end
    end
`else
    assign mag = bin_d_in;
`endif

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = SETUP;
            SETUP:   state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = (cnt_q == CNT_ONE) ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            bcd_d_out <= '0;
            ovf       <= 1'b0;
            rdy       <= 1'b0;
`ifdef BCD_CONV_SIGNED_EN
            sign_q    <= 1'b0;
            sign_out  <= 1'b0;
`endif
        end else begin
            rdy <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        bin_q    <= mag;
                        bcd_q    <= '0;
                        sticky_q <= 1'b0;
`ifdef BCD_CONV_SIGNED_EN
                        sign_q   <= sign_in;
`endif
                    end
                end
                SETUP: cnt_q <= CNT_LOAD;
                ADD:   bcd_q <= bcd_adj;
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_q, bin_q} << 1;
                    sticky_q       <= sticky_q | bcd_q[BW-1];
                    cnt_q          <= cnt_q - CNT_ONE;
                end
                DONE: begin
                    bcd_d_out <= bcd_q;
                    ovf       <= sticky_q;
                    rdy       <= 1'b1;
`ifdef BCD_CONV_SIGNED_EN
                    sign_out  <= sign_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_param.sv
// Self-checking bench: default (12/4) and 14/4 converters against a decimal reference model.
module tb_bcd_conv_param;

    localparam int BW_A = 12;
    localparam int DG_A = 4;
    localparam int BW_B = 14;
    localparam int DG_B = 4;
    localparam int LAT_A = 2 * BW_A + 2;
    localparam int LAT_B = 2 * BW_B + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [11:0] bin_a;
    logic [13:0] bin_b;
    logic [15:0] bcd_a, bcd_b;
    logic        rdy_a, rdy_b, busy_a, busy_b, ovf_a, ovf_b;
`ifdef BCD_CONV_SIGNED_EN
    logic        sign_a, sign_b;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_a;

    always #5 clk = ~clk;

    bcd_conv_param #(.BIN_W(BW_A), .DIGITS(DG_A)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_a),
        .bin_d_in  (bin_a),
        .bcd_d_out (bcd_a),
        .rdy       (rdy_a),
        .busy      (busy_a),
        .ovf       (ovf_a)
`ifdef BCD_CONV_SIGNED_EN
        ,
        .sign_out  (sign_a)
`endif
    );

    bcd_conv_param #(.BIN_W(BW_B), .DIGITS(DG_B)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_b),
        .bin_d_in  (bin_b),
        .bcd_d_out (bcd_b),
        .rdy       (rdy_b),
        .busy      (busy_b),
        .ovf       (ovf_b)
`ifdef BCD_CONV_SIGNED_EN
        ,
        .sign_out  (sign_b)
`endif
    );

    // Reference: decimal digits of the magnitude, modulo 10^digits.
    function automatic void model(input logic [31:0] raw, input int bw, input int digits,
                                  output logic [39:0] exp_bcd, output logic exp_ovf,
                                  output logic exp_sign);
        longint unsigned mag;
        longint unsigned lim;
        longint unsigned m;
        logic s;
        mag = longint'(raw) & ((64'd1 << bw) - 64'd1);
        s = 1'b0;
`ifdef BCD_CONV_SIGNED_EN
        s = raw[bw-1];
        if (s) mag = (64'd1 << bw) - mag;
`endif
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        exp_ovf = (mag >= lim);
        m = mag % lim;
        exp_bcd = '0;
        for (int i = 0; i < digits; i++) begin
            exp_bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        exp_sign = s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_res(input int which, input logic [31:0] raw, input string tag);
        logic [39:0] eb;
        logic eo, es;
        if (which == 0) begin
            model(raw, BW_A, DG_A, eb, eo, es);
            chk({tag, "_bcd"}, 64'(bcd_a), 64'(eb[15:0]));
            chk({tag, "_ovf"}, 64'(ovf_a), 64'(eo));
`ifdef BCD_CONV_SIGNED_EN
            chk({tag, "_sign"}, 64'(sign_a), 64'(es));
`endif
        end else begin
            model(raw, BW_B, DG_B, eb, eo, es);
            chk({tag, "_bcd"}, 64'(bcd_b), 64'(eb[15:0]));
            chk({tag, "_ovf"}, 64'(ovf_b), 64'(eo));
`ifdef BCD_CONV_SIGNED_EN
            chk({tag, "_sign"}, 64'(sign_b), 64'(es));
`endif
        end
    endtask

    // One conversion: checks latency to rdy and the number of busy cycles before it.
    task automatic do_conv(input int which, input logic [31:0] raw, input string tag);
        int j;
        int busy_cnt;
        @(negedge clk);
        if (which == 0) begin en_a = 1'b1; bin_a = raw[11:0]; end
        else            begin en_b = 1'b1; bin_b = raw[13:0]; end
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        j = 0;
        busy_cnt = 0;
        while (!((which == 0) ? rdy_a : rdy_b) && j < 100) begin
            if ((which == 0) ? busy_a : busy_b) busy_cnt++;
            @(negedge clk);
            j++;
        end
        chk({tag, "_latency"}, 64'(j), 64'((which == 0) ? LAT_A : LAT_B));
        chk({tag, "_busycnt"}, 64'(busy_cnt), 64'((which == 0) ? LAT_A : LAT_B));
        chk_res(which, raw, tag);
        if (which == 0) last_a = raw;
    endtask

    initial begin
        int rdy_cnt;
        int t1, t2;
        logic [39:0] eb;
        logic eo, es;
        logic [31:0] r;
        logic [31:0] dir_a [7];
        logic [31:0] dir_b [3];

        dir_a = '{32'h000, 32'hFFF, 32'd1, 32'd11, 32'd21, 32'd121, 32'h800};
        dir_b = '{32'd9999, 32'd10000, 32'd16383};

        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        bin_a = '0;  bin_b = '0;
        last_a = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd",  64'(bcd_a),  64'h0);
        chk("rst_rdy",  64'(rdy_a),  64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_ovf",  64'(ovf_a),  64'h0);
        rst_n = 1'b1;

        foreach (dir_a[i]) begin
            do_conv(0, dir_a[i], $sformatf("a_dir%0d", i));
            @(negedge clk);
            chk("a_rdy_pulse", 64'(rdy_a), 64'h0);
        end
        do_conv(0, 32'h7FF, "a_7ff");
        foreach (dir_b[i]) do_conv(1, dir_b[i], $sformatf("b_dir%0d", i));

        // Extra en while busy and operand change mid-conversion are ignored.
        model(last_a, BW_A, DG_A, eb, eo, es);
        @(negedge clk);
        en_a = 1'b1; bin_a = 12'hFFF;
        @(negedge clk);
        rdy_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            if (rdy_a) rdy_cnt++;
            if (j == 10) chk("hold_bcd", 64'(bcd_a), 64'(eb[15:0]));
            en_a = (j == 4);
            if (j == 8) bin_a = 12'd7;
            @(negedge clk);
        end
        chk("ignore_en_rdy_count", 64'(rdy_cnt), 64'd1);
        chk_res(0, 32'hFFF, "ignore_en");
        last_a = 32'hFFF;

        // Reset mid-conversion.
        @(negedge clk);
        en_a = 1'b1; bin_a = 12'd999;
        @(negedge clk);
        en_a = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd",  64'(bcd_a),  64'h0);
        chk("midrst_busy", 64'(busy_a), 64'h0);
        chk("midrst_rdy",  64'(rdy_a),  64'h0);
        chk("midrst_ovf",  64'(ovf_a),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            if (rdy_a || busy_a) rdy_cnt++;
            @(negedge clk);
        end
        chk("midrst_quiet", 64'(rdy_cnt), 64'h0);
        do_conv(0, 32'd999, "after_rst");

        // en held high restarts on the first IDLE edge after each DONE.
        @(negedge clk);
        en_a = 1'b1; bin_a = 12'd121;
        t1 = -1; t2 = -1;
        for (int j = 0; j < 120 && t2 < 0; j++) begin
            @(negedge clk);
            if (rdy_a) begin
                if (t1 < 0) t1 = j; else t2 = j;
            end
        end
        en_a = 1'b0;
        chk("cont_gap", 64'(t2 - t1), 64'(LAT_A + 1));
        chk_res(0, 32'd121, "cont");
        repeat (40) @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            r = $urandom;
            do_conv(0, {20'd0, r[11:0]}, $sformatf("rnd_a%0d", k));
            r = $urandom;
            do_conv(1, {18'd0, r[13:0]}, $sformatf("rnd_b%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
